mips_mc_ctrl: RTL and testbench
===============================

Name: mips_mc_ctrl

Overview:
Multi-cycle main controller, directly downstream of the instruction fetch unit. It latches the fetched instruction word and steps an FSM through FETCH/DECODE/EXEC/MEM/WB. It drives the fetch unit's next-PC selects (nPC_sel, j_sel, jValue) plus a one-cycle PC write enable. It also drives datapath controls for register file, ALU, extender and data memory.

Parameters:
CNT_W, 32, width of retired-instruction counter (wraps modulo 2^CNT_W)
ILLEGAL_HALT, 1, 1 = illegal opcode enters sticky TRAP; 0 = retire as NOP (pc+4)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
instruction  in  32  word from fetch unit at current PC
zero  in  32  ALU result; passed to fetch unit, not used internally
ir  out  32  latched instruction register
pc_we  out  1  PC write enable; exactly one pulse per retired instruction
nPC_sel  out  2  00 pc+4, 01 pc+4+offset, 10 BEQ, 11 BNE (fetch unit evaluates zero)
j_sel  out  1  1 = absolute jump target
jValue  out  26  always ir[25:0]
reg_we  out  1  register-file write
reg_dst  out  2  00 rt, 01 rd, 10 $31
alu_src  out  1  0 = rt, 1 = extended imm
alu_op  out  2  00 ADD, 01 SUB, 10 OR, 11 LUI
ext_op  out  1  0 = zero-ext, 1 = sign-ext
mem_we  out  1  data-memory write
mem_to_reg  out  2  00 ALU, 01 memory, 10 pc+4
illegal  out  1  sticky trap flag
instr_cnt  out  CNT_W  retired instructions
state  out  4  current FSM state (debug)

Behaviour:
- Reset (async): state=FETCH; ir=0; instr_cnt=0; illegal=0; all controls 0 (nPC_sel=00, j_sel=0).
- Reset mid-instruction abandons it. No pc_we or reg_we/mem_we is issued for the aborted instruction.
- All outputs are Moore outputs: registered state plus latched ir. No combinational path from instruction to outputs.
- FETCH(0): ir_load; ir <= instruction at the clock edge; -> DECODE.
- DECODE(1): classify ir[31:26], ir[5:0]:
  - R-type (op 000000; funct 100001 addu, 100011 subu) -> EXEC_R.
  - ori 001101, lui 001111 -> EXEC_I.
  - lw 100011, sw 101011 -> MEM_ADR.
  - beq 000100, bne 000101 -> BRANCH.
  - j 000010, jal 000011 -> JUMP.
  - Anything else -> TRAP if ILLEGAL_HALT, otherwise NOP_RET.
- EXEC_R(2): alu_src=0; alu_op=ADD/SUB from funct; -> WB_R.
- WB_R(3): reg_we=1; reg_dst=01; mem_to_reg=00; pc_we=1; -> FETCH.
- EXEC_I(4): alu_src=1; ext_op=0; alu_op=OR/LUI; -> WB_I.
- WB_I(5): reg_we=1; reg_dst=00; pc_we=1; -> FETCH.
- MEM_ADR(6): alu_src=1; ext_op=1; alu_op=ADD; -> MEM_RD (lw) or MEM_WR (sw).
- MEM_RD(7): address held; -> WB_MEM.
- WB_MEM(8): reg_we=1; reg_dst=00; mem_to_reg=01; pc_we=1; -> FETCH.
- MEM_WR(9): mem_we=1; pc_we=1; -> FETCH.
- BRANCH(10): alu_src=0; alu_op=SUB; ext_op=1; nPC_sel=10 (beq) or 11 (bne); pc_we=1; -> FETCH.
- JUMP(11): j_sel=1; pc_we=1; for jal: reg_we=1, reg_dst=10, mem_to_reg=10; -> FETCH.
- NOP_RET(12): nPC_sel=00; pc_we=1; -> FETCH.
- TRAP(13): illegal=1; all enables 0; stays until rst.
- Latency: branch/jump 3 cycles; R, I and sw 4; lw 5.
- Outside BRANCH: nPC_sel=00. Outside JUMP: j_sel=0.
- ir changes only in FETCH.
- instr_cnt increments on every pc_we cycle; wraps all-ones -> 0.
- Undefined state encodings (14, 15) -> FETCH on next edge, no enables asserted.

Decomposition:
- Package mips_ctrl_pkg holds:
  - opcode and funct constants
  - state encoding localparams
  - alu_op, nPC_sel, reg_dst and mem_to_reg codes
- One combinational sub-module, mips_ctrl_decode: ir -> one-hot instruction class {rtype_add, rtype_sub, ori, lui, lw, sw, beq, bne, j, jal, bad}. The FSM consumes only these class bits.

Test Plan:
- Reset: assert rst mid-WB_MEM -> immediate state=0; ir=0; pc_we=0; reg_we=0; instr_cnt=0.
- addu $3,$1,$2 (0x00221821) -> states 0,1,2,3. In state 3: reg_we=1, reg_dst=01, pc_we=1, nPC_sel=00. instr_cnt=1 afterwards.
- lw $2,4($1) (0x8C220004) -> 5 cycles. alu_src=1 and ext_op=1 in MEM_ADR; mem_to_reg=01 and reg_we=1 only in WB_MEM. Exactly one pc_we pulse.
- beq $1,$2,-1 (0x1022FFFF) -> 3 cycles. BRANCH: nPC_sel=10, alu_op=01, pc_we=1. Repeat with bne 0x1422FFFF -> nPC_sel=11.
- j 0x0100000 (0x08100000) -> JUMP: j_sel=1, jValue=0x0100000, reg_we=0. jal 0x0C100000 -> additionally reg_we=1, reg_dst=10, mem_to_reg=10.
- Illegal 0xFC000000 with ILLEGAL_HALT=1 -> TRAP, illegal=1, no pc_we for 20 cycles, instr_cnt frozen. With ILLEGAL_HALT=0 -> NOP_RET, pc_we=1, nPC_sel=00. Also preload instr_cnt near wrap and confirm all-ones -> 0.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcode/funct values,
// FSM state numbering, datapath select codes and the small helpers that map
// (state, instruction class) to the next state and to the control word.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;

  localparam logic [3:0] ST_FETCH   = 4'd0;
  localparam logic [3:0] ST_DECODE  = 4'd1;
  localparam logic [3:0] ST_EXEC_R  = 4'd2;
  localparam logic [3:0] ST_WB_R    = 4'd3;
  localparam logic [3:0] ST_EXEC_I  = 4'd4;
  localparam logic [3:0] ST_WB_I    = 4'd5;
  localparam logic [3:0] ST_MEM_ADR = 4'd6;
  localparam logic [3:0] ST_MEM_RD  = 4'd7;
  localparam logic [3:0] ST_WB_MEM  = 4'd8;
  localparam logic [3:0] ST_MEM_WR  = 4'd9;
  localparam logic [3:0] ST_BRANCH  = 4'd10;
  localparam logic [3:0] ST_JUMP    = 4'd11;
  localparam logic [3:0] ST_NOP_RET = 4'd12;
  localparam logic [3:0] ST_TRAP    = 4'd13;

  typedef enum logic [3:0] {
    S_FETCH   = ST_FETCH,
    S_DECODE  = ST_DECODE,
    S_EXEC_R  = ST_EXEC_R,
    S_WB_R    = ST_WB_R,
    S_EXEC_I  = ST_EXEC_I,
    S_WB_I    = ST_WB_I,
    S_MEM_ADR = ST_MEM_ADR,
    S_MEM_RD  = ST_MEM_RD,
    S_WB_MEM  = ST_WB_MEM,
    S_MEM_WR  = ST_MEM_WR,
    S_BRANCH  = ST_BRANCH,
    S_JUMP    = ST_JUMP,
    S_NOP_RET = ST_NOP_RET,
    S_TRAP    = ST_TRAP
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_OR  = 2'b10;
  localparam logic [1:0] ALU_LUI = 2'b11;

  localparam logic [1:0] NPC_SEQ = 2'b00;
  localparam logic [1:0] NPC_OFS = 2'b01;
  localparam logic [1:0] NPC_BEQ = 2'b10;
  localparam logic [1:0] NPC_BNE = 2'b11;

  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MEM = 2'b01;
  localparam logic [1:0] M2R_PC4 = 2'b10;

  // One-hot instruction class; exactly one bit is set for any instruction word.
  typedef struct packed {
    logic rtypeAdd;
    logic rtypeSub;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic bne;
    logic j;
    logic jal;
    logic bad;
  } instrClass_t;

  // Complete set of registered controls presented to fetch unit and datapath.
  typedef struct packed {
    logic       pcWe;
    logic [1:0] nPcSel;
    logic       jSel;
    logic       regWe;
    logic [1:0] regDst;
    logic       aluSrc;
    logic [1:0] aluOp;
    logic       extOp;
    logic       memWe;
    logic [1:0] memToReg;
    logic       illegal;
  } ctrl_t;

  // Successor state; every retiring state returns to FETCH, unused codes too.
  function automatic state_t nextState(state_t s, instrClass_t c, logic haltOnBad);
    state_t n;
    n = S_FETCH;
    case (s)
      S_FETCH:   n = S_DECODE;
      S_DECODE: begin
        if (c.rtypeAdd | c.rtypeSub) n = S_EXEC_R;
        else if (c.ori | c.lui)      n = S_EXEC_I;
        else if (c.lw | c.sw)        n = S_MEM_ADR;
        else if (c.beq | c.bne)      n = S_BRANCH;
        else if (c.j | c.jal)        n = S_JUMP;
        else if (haltOnBad)          n = S_TRAP;
        else                         n = S_NOP_RET;
      end
      S_EXEC_R:  n = S_WB_R;
      S_EXEC_I:  n = S_WB_I;
      S_MEM_ADR: n = c.lw ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:  n = S_WB_MEM;
      S_TRAP:    n = S_TRAP;
      S_WB_R, S_WB_I, S_WB_MEM, S_MEM_WR,
      S_BRANCH, S_JUMP, S_NOP_RET: n = S_FETCH;
      default:   n = S_FETCH;
    endcase
    return n;
  endfunction

  // Control word for a state. There is no ALUOut latch in this datapath, so the
  // ALU selects stay asserted through the write-back / memory-access cycles
  // that consume the ALU result.
  function automatic ctrl_t ctrlFor(state_t s, instrClass_t c);
    ctrl_t k;
    k = '0;
    case (s)
      S_EXEC_R: begin
        k.aluOp = c.rtypeSub ? ALU_SUB : ALU_ADD;
      end
      S_WB_R: begin
        k.aluOp    = c.rtypeSub ? ALU_SUB : ALU_ADD;
        k.regWe    = 1'b1;
        k.regDst   = DST_RD;
        k.memToReg = M2R_ALU;
        k.pcWe     = 1'b1;
      end
      S_EXEC_I: begin
        k.aluSrc = 1'b1;
        k.aluOp  = c.lui ? ALU_LUI : ALU_OR;
      end
      S_WB_I: begin
        k.aluSrc = 1'b1;
        k.aluOp  = c.lui ? ALU_LUI : ALU_OR;
        k.regWe  = 1'b1;
        k.regDst = DST_RT;
        k.pcWe   = 1'b1;
      end
      S_MEM_ADR, S_MEM_RD: begin
        k.aluSrc = 1'b1;
        k.extOp  = 1'b1;
        k.aluOp  = ALU_ADD;
      end
      S_WB_MEM: begin
        k.regWe    = 1'b1;
        k.regDst   = DST_RT;
        k.memToReg = M2R_MEM;
        k.pcWe     = 1'b1;
      end
      S_MEM_WR: begin
        k.aluSrc = 1'b1;
        k.extOp  = 1'b1;
        k.memWe  = 1'b1;
        k.pcWe   = 1'b1;
      end
      S_BRANCH: begin
        k.aluOp  = ALU_SUB;
        k.extOp  = 1'b1;
        k.nPcSel = c.bne ? NPC_BNE : NPC_BEQ;
        k.pcWe   = 1'b1;
      end
      S_JUMP: begin
        k.jSel = 1'b1;
        k.pcWe = 1'b1;
        if (c.jal) begin
          k.regWe    = 1'b1;
          k.regDst   = DST_RA;
          k.memToReg = M2R_PC4;
        end
      end
      S_NOP_RET: begin
        k.nPcSel = NPC_SEQ;
        k.pcWe   = 1'b1;
      end
      S_TRAP: begin
        k.illegal = 1'b1;
      end
      default: k = '0;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// Instruction classifier: opcode and funct fields to a one-hot class vector.
// Anything not in the supported subset lands in the 'bad' class.
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0]  i_op,
  input  logic [5:0]  i_funct,
  output instrClass_t o_class
);

  // Pure table lookup on the opcode, with funct refining the R-type group.
  always_comb begin
    o_class = '0;
    case (i_op)
      OP_RTYPE: begin
        if (i_funct == FN_ADDU)      o_class.rtypeAdd = 1'b1;
        else if (i_funct == FN_SUBU) o_class.rtypeSub = 1'b1;
        else                         o_class.bad      = 1'b1;
      end
      OP_ORI:  o_class.ori = 1'b1;
      OP_LUI:  o_class.lui = 1'b1;
      OP_LW:   o_class.lw  = 1'b1;
      OP_SW:   o_class.sw  = 1'b1;
      OP_BEQ:  o_class.beq = 1'b1;
      OP_BNE:  o_class.bne = 1'b1;
      OP_J:    o_class.j   = 1'b1;
      OP_JAL:  o_class.jal = 1'b1;
      default: o_class.bad = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle main controller. Latches the fetched word in FETCH, classifies
// it, then walks the per-class state sequence. All outputs come from
// registers (state, ir, control word, counter), so there is no combinational
// path from the instruction input to any output.
module mips_mc_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter int ILLEGAL_HALT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instruction,
  input  logic [31:0]      zero,
  output logic [31:0]      ir,
  output logic             pc_we,
  output logic [1:0]       nPC_sel,
  output logic             j_sel,
  output logic [25:0]      jValue,
  output logic             reg_we,
  output logic [1:0]       reg_dst,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic             ext_op,
  output logic             mem_we,
  output logic [1:0]       mem_to_reg,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [3:0]       state
);

  localparam logic HALT_ON_BAD = (ILLEGAL_HALT != 0);

  state_t           r_state;
  logic [31:0]      r_ir;
  ctrl_t            r_ctrl;
  logic [CNT_W-1:0] r_cnt;
  instrClass_t      w_class;
  state_t           w_nextState;
  logic             w_unusedZero;

  // The ALU zero/result word is consumed by the fetch unit, not here.
  assign w_unusedZero = ^zero;

  mips_ctrl_decode u_decode (
    .i_op    (r_ir[31:26]),
    .i_funct (r_ir[5:0]),
    .o_class (w_class)
  );

  assign w_nextState = nextState(r_state, w_class, HALT_ON_BAD);

  // FSM: advance state, load ir only while leaving FETCH, and register the
  // control word belonging to the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_ir    <= '0;
      r_ctrl  <= '0;
    end else begin
      r_state <= w_nextState;
      r_ctrl  <= ctrlFor(w_nextState, w_class);
      if (r_state == S_FETCH) begin
        r_ir <= instruction;
      end
    end
  end

  // Retired-instruction counter: one count per PC write, wrapping naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_ctrl.pcWe) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign ir         = r_ir;
  assign jValue     = r_ir[25:0];
  assign pc_we      = r_ctrl.pcWe;
  assign nPC_sel    = r_ctrl.nPcSel;
  assign j_sel      = r_ctrl.jSel;
  assign reg_we     = r_ctrl.regWe;
  assign reg_dst    = r_ctrl.regDst;
  assign alu_src    = r_ctrl.aluSrc;
  assign alu_op     = r_ctrl.aluOp;
  assign ext_op     = r_ctrl.extOp;
  assign mem_we     = r_ctrl.memWe;
  assign mem_to_reg = r_ctrl.memToReg;
  assign illegal    = r_ctrl.illegal;
  assign instr_cnt  = r_cnt;
  assign state      = r_state;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Bench for mips_mc_ctrl: one halting and one non-halting instance share the
// same stimulus; a cycle-indexed instruction model predicts every output.
module tb_mips_mc_ctrl;

  localparam int CW = 4;
  localparam int H  = 0;
  localparam int N  = 1;

  localparam int K_ADDU = 0;
  localparam int K_SUBU = 1;
  localparam int K_ORI  = 2;
  localparam int K_LUI  = 3;
  localparam int K_LW   = 4;
  localparam int K_SW   = 5;
  localparam int K_BEQ  = 6;
  localparam int K_BNE  = 7;
  localparam int K_J    = 8;
  localparam int K_JAL  = 9;
  localparam int K_BAD  = 10;

  typedef struct packed {
    logic [3:0] st;
    logic       pcWe;
    logic [1:0] nPc;
    logic       jSel;
    logic       regWe;
    logic [1:0] regDst;
    logic       aluSrc;
    logic [1:0] aluOp;
    logic       extOp;
    logic       memWe;
    logic [1:0] m2r;
    logic       ill;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   instruction = 32'h0;
  logic [31:0]   zero = 32'h0;

  logic [31:0]   irO[2];
  logic          pcWeO[2];
  logic [1:0]    nPcO[2];
  logic          jSelO[2];
  logic [25:0]   jValO[2];
  logic          regWeO[2];
  logic [1:0]    regDstO[2];
  logic          aluSrcO[2];
  logic [1:0]    aluOpO[2];
  logic          extOpO[2];
  logic          memWeO[2];
  logic [1:0]    m2rO[2];
  logic          illO[2];
  logic [CW-1:0] cntO[2];
  logic [3:0]    stO[2];

  int passCount  = 0;
  int checkCount = 0;

  logic [31:0] mIr[2];
  int          mIdx[2];
  int          mCnt[2];
  exp_t        mRec;
  exp_t        cRec;

  always #5 clk = ~clk;

  mips_mc_ctrl #(.CNT_W(CW), .ILLEGAL_HALT(1)) dutHalt (
    .clk(clk), .rst(rst), .instruction(instruction), .zero(zero),
    .ir(irO[H]), .pc_we(pcWeO[H]), .nPC_sel(nPcO[H]), .j_sel(jSelO[H]),
    .jValue(jValO[H]), .reg_we(regWeO[H]), .reg_dst(regDstO[H]),
    .alu_src(aluSrcO[H]), .alu_op(aluOpO[H]), .ext_op(extOpO[H]),
    .mem_we(memWeO[H]), .mem_to_reg(m2rO[H]), .illegal(illO[H]),
    .instr_cnt(cntO[H]), .state(stO[H])
  );

  mips_mc_ctrl #(.CNT_W(CW), .ILLEGAL_HALT(0)) dutNop (
    .clk(clk), .rst(rst), .instruction(instruction), .zero(zero),
    .ir(irO[N]), .pc_we(pcWeO[N]), .nPC_sel(nPcO[N]), .j_sel(jSelO[N]),
    .jValue(jValO[N]), .reg_we(regWeO[N]), .reg_dst(regDstO[N]),
    .alu_src(aluSrcO[N]), .alu_op(aluOpO[N]), .ext_op(extOpO[N]),
    .mem_we(memWeO[N]), .mem_to_reg(m2rO[N]), .illegal(illO[N]),
    .instr_cnt(cntO[N]), .state(stO[N])
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checkCount++;
    if (act !== expv) begin
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end else begin
      passCount++;
    end
  endtask

  // Instruction kind from the architectural opcode/funct tables.
  function automatic int kindOf(input logic [31:0] ins);
    case (ins[31:26])
      6'h00:   return (ins[5:0] == 6'h21) ? K_ADDU : ((ins[5:0] == 6'h23) ? K_SUBU : K_BAD);
      6'h0D:   return K_ORI;
      6'h0F:   return K_LUI;
      6'h23:   return K_LW;
      6'h2B:   return K_SW;
      6'h04:   return K_BEQ;
      6'h05:   return K_BNE;
      6'h02:   return K_J;
      6'h03:   return K_JAL;
      default: return K_BAD;
    endcase
  endfunction

  // Cycles from FETCH to retirement inclusive.
  function automatic int instrLen(input int k, input bit halt);
    case (k)
      K_LW:                      return 5;
      K_BEQ, K_BNE, K_J, K_JAL:  return 3;
      K_BAD:                     return halt ? 1000 : 3;
      default:                   return 4;
    endcase
  endfunction

  // Expected outputs during cycle 'idx' of executing 'ins' (0 = FETCH).
  function automatic exp_t cycleRec(input logic [31:0] ins, input bit halt, input int idx);
    exp_t r;
    int   k;
    r = '0;
    k = kindOf(ins);
    if (idx == 0) return r;
    if (idx == 1) begin
      r.st = 4'd1;
      return r;
    end
    case (k)
      K_ADDU, K_SUBU: begin
        r.aluOp = (k == K_SUBU) ? 2'd1 : 2'd0;
        if (idx == 2) r.st = 4'd2;
        else begin
          r.st = 4'd3; r.regWe = 1'b1; r.regDst = 2'd1; r.pcWe = 1'b1;
        end
      end
      K_ORI, K_LUI: begin
        r.aluSrc = 1'b1;
        r.aluOp  = (k == K_ORI) ? 2'd2 : 2'd3;
        if (idx == 2) r.st = 4'd4;
        else begin
          r.st = 4'd5; r.regWe = 1'b1; r.pcWe = 1'b1;
        end
      end
      K_LW: begin
        if (idx == 2) begin
          r.st = 4'd6; r.aluSrc = 1'b1; r.extOp = 1'b1;
        end else if (idx == 3) begin
          r.st = 4'd7; r.aluSrc = 1'b1; r.extOp = 1'b1;
        end else begin
          r.st = 4'd8; r.regWe = 1'b1; r.m2r = 2'd1; r.pcWe = 1'b1;
        end
      end
      K_SW: begin
        r.aluSrc = 1'b1; r.extOp = 1'b1;
        if (idx == 2) r.st = 4'd6;
        else begin
          r.st = 4'd9; r.memWe = 1'b1; r.pcWe = 1'b1;
        end
      end
      K_BEQ, K_BNE: begin
        r.st = 4'd10; r.aluOp = 2'd1; r.extOp = 1'b1; r.pcWe = 1'b1;
        r.nPc = (k == K_BEQ) ? 2'd2 : 2'd3;
      end
      K_J, K_JAL: begin
        r.st = 4'd11; r.jSel = 1'b1; r.pcWe = 1'b1;
        if (k == K_JAL) begin
          r.regWe = 1'b1; r.regDst = 2'd2; r.m2r = 2'd2;
        end
      end
      default: begin
        if (halt) begin
          r.st = 4'd13; r.ill = 1'b1;
        end else begin
          r.st = 4'd12; r.pcWe = 1'b1;
        end
      end
    endcase
    return r;
  endfunction

  // Reference model: tracks latched word, position within it and retire count.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        mIr[k] = 32'h0; mIdx[k] = 0; mCnt[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        mRec = cycleRec(mIr[k], (k == H), mIdx[k]);
        if (mRec.pcWe) mCnt[k] = (mCnt[k] + 1) % (1 << CW);
        if (mIdx[k] == 0) begin
          mIr[k]  = instruction;
          mIdx[k] = 1;
        end else if (mRec.st == 4'd13) begin
          mIdx[k] = mIdx[k];
        end else if (mIdx[k] + 1 >= instrLen(kindOf(mIr[k]), (k == H))) begin
          mIdx[k] = 0;
        end else begin
          mIdx[k] = mIdx[k] + 1;
        end
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        cRec = cycleRec(mIr[k], (k == H), mIdx[k]);
        checkOutput($sformatf("state[%0d]", k),      {28'h0, stO[k]},     {28'h0, cRec.st});
        checkOutput($sformatf("ir[%0d]", k),         irO[k],              mIr[k]);
        checkOutput($sformatf("jValue[%0d]", k),     {6'h0, jValO[k]},    {6'h0, mIr[k][25:0]});
        checkOutput($sformatf("pc_we[%0d]", k),      {31'h0, pcWeO[k]},   {31'h0, cRec.pcWe});
        checkOutput($sformatf("nPC_sel[%0d]", k),    {30'h0, nPcO[k]},    {30'h0, cRec.nPc});
        checkOutput($sformatf("j_sel[%0d]", k),      {31'h0, jSelO[k]},   {31'h0, cRec.jSel});
        checkOutput($sformatf("reg_we[%0d]", k),     {31'h0, regWeO[k]},  {31'h0, cRec.regWe});
        checkOutput($sformatf("reg_dst[%0d]", k),    {30'h0, regDstO[k]}, {30'h0, cRec.regDst});
        checkOutput($sformatf("alu_src[%0d]", k),    {31'h0, aluSrcO[k]}, {31'h0, cRec.aluSrc});
        checkOutput($sformatf("alu_op[%0d]", k),     {30'h0, aluOpO[k]},  {30'h0, cRec.aluOp});
        checkOutput($sformatf("ext_op[%0d]", k),     {31'h0, extOpO[k]},  {31'h0, cRec.extOp});
        checkOutput($sformatf("mem_we[%0d]", k),     {31'h0, memWeO[k]},  {31'h0, cRec.memWe});
        checkOutput($sformatf("mem_to_reg[%0d]", k), {30'h0, m2rO[k]},    {30'h0, cRec.m2r});
        checkOutput($sformatf("illegal[%0d]", k),    {31'h0, illO[k]},    {31'h0, cRec.ill});
        checkOutput($sformatf("instr_cnt[%0d]", k),  {28'h0, cntO[k]},    mCnt[k]);
      end
    end
  end

  function automatic exp_t sampleDut(input int k);
    exp_t r;
    r.st = stO[k]; r.pcWe = pcWeO[k]; r.nPc = nPcO[k]; r.jSel = jSelO[k];
    r.regWe = regWeO[k]; r.regDst = regDstO[k]; r.aluSrc = aluSrcO[k];
    r.aluOp = aluOpO[k]; r.extOp = extOpO[k]; r.memWe = memWeO[k];
    r.m2r = m2rO[k]; r.ill = illO[k];
    return r;
  endfunction

  // Present one instruction while in FETCH and follow the non-halting
  // instance until it is back in FETCH, recording its state trace.
  task automatic applyStimulus(input logic [31:0] ins, output int cyc, output int pulses,
                               output int regWes, output logic [31:0] trace,
                               output exp_t snap2, output exp_t snapLast);
    bit done;
    instruction = ins;
    zero = $urandom;
    cyc = 1; pulses = 0; regWes = 0; trace = 32'h0; snap2 = '0; snapLast = '0;
    done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (stO[N] == 4'd0) begin
        done = 1'b1;
        break;
      end
      trace = {trace[27:0], stO[N]};
      cyc++;
      pulses += int'(pcWeO[N]);
      regWes += int'(regWeO[N]);
      if (cyc == 3) snap2 = sampleDut(N);
      snapLast = sampleDut(N);
    end
    if (!done) checkOutput("retireTimeout", 32'd0, 32'd1);
  endtask

  task automatic doReset();
    @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  function automatic logic [31:0] randInstr(input int k);
    logic [31:0] ins;
    ins = $urandom;
    case (k)
      K_ADDU: begin ins[31:26] = 6'h00; ins[5:0] = 6'h21; end
      K_SUBU: begin ins[31:26] = 6'h00; ins[5:0] = 6'h23; end
      K_ORI:  ins[31:26] = 6'h0D;
      K_LUI:  ins[31:26] = 6'h0F;
      K_LW:   ins[31:26] = 6'h23;
      K_SW:   ins[31:26] = 6'h2B;
      K_BEQ:  ins[31:26] = 6'h04;
      K_BNE:  ins[31:26] = 6'h05;
      K_J:    ins[31:26] = 6'h02;
      K_JAL:  ins[31:26] = 6'h03;
      default: begin
        for (int t = 0; t < 100 && kindOf(ins) != K_BAD; t++) ins = $urandom;
        if (kindOf(ins) != K_BAD) ins = 32'hFC000000;
      end
    endcase
    return ins;
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          cyc, pulses, regWes, hPulses, k;
    logic [31:0] trace;
    exp_t        s2, sl;

    doReset();
    // Reset values, sampled just after release and before the first edge.
    checkOutput("rst_state", {28'h0, stO[N]}, 32'd0);
    checkOutput("rst_ir", irO[N], 32'd0);
    checkOutput("rst_cnt", {28'h0, cntO[N]}, 32'd0);
    checkOutput("rst_pc_we", {31'h0, pcWeO[N]}, 32'd0);

    applyStimulus(32'h00221821, cyc, pulses, regWes, trace, s2, sl);
    checkOutput("addu_trace", trace, 32'h123);
    checkOutput("addu_cycles", cyc, 32'd4);
    checkOutput("addu_wb_reg_we", {31'h0, sl.regWe}, 32'd1);
    checkOutput("addu_wb_reg_dst", {30'h0, sl.regDst}, 32'd1);
    checkOutput("addu_wb_pc_we", {31'h0, sl.pcWe}, 32'd1);
    checkOutput("addu_wb_nPC_sel", {30'h0, sl.nPc}, 32'd0);
    checkOutput("addu_cnt", {28'h0, cntO[N]}, 32'd1);

    applyStimulus(32'h8C220004, cyc, pulses, regWes, trace, s2, sl);
    checkOutput("lw_trace", trace, 32'h1678);
    checkOutput("lw_cycles", cyc, 32'd5);
    checkOutput("lw_pc_we_pulses", pulses, 32'd1);
    checkOutput("lw_reg_we_pulses", regWes, 32'd1);
    checkOutput("lw_adr_alu_src", {31'h0, s2.aluSrc}, 32'd1);
    checkOutput("lw_adr_ext_op", {31'h0, s2.extOp}, 32'd1);
    checkOutput("lw_wb_mem_to_reg", {30'h0, sl.m2r}, 32'd1);

    applyStimulus(32'h1022FFFF, cyc, pulses, regWes, trace, s2, sl);
    checkOutput("beq_trace", trace, 32'h1A);
    checkOutput("beq_cycles", cyc, 32'd3);
    checkOutput("beq_nPC_sel", {30'h0, sl.nPc}, 32'd2);
    checkOutput("beq_alu_op", {30'h0, sl.aluOp}, 32'd1);
    checkOutput("beq_pc_we", {31'h0, sl.pcWe}, 32'd1);

    applyStimulus(32'h1422FFFF, cyc, pulses, regWes, trace, s2, sl);
    checkOutput("bne_nPC_sel", {30'h0, sl.nPc}, 32'd3);

    applyStimulus(32'h08100000, cyc, pulses, regWes, trace, s2, sl);
    checkOutput("j_trace", trace, 32'h1B);
    checkOutput("j_j_sel", {31'h0, sl.jSel}, 32'd1);
    checkOutput("j_reg_we", {31'h0, sl.regWe}, 32'd0);
    checkOutput("j_jValue", {6'h0, jValO[N]}, 32'h0100000);

    applyStimulus(32'h0C100000, cyc, pulses, regWes, trace, s2, sl);
    checkOutput("jal_j_sel", {31'h0, sl.jSel}, 32'd1);
    checkOutput("jal_reg_we", {31'h0, sl.regWe}, 32'd1);
    checkOutput("jal_reg_dst", {30'h0, sl.regDst}, 32'd2);
    checkOutput("jal_mem_to_reg", {30'h0, sl.m2r}, 32'd2);
    checkOutput("cnt_after6_nop", {28'h0, cntO[N]}, 32'd6);
    checkOutput("cnt_after6_halt", {28'h0, cntO[H]}, 32'd6);

    applyStimulus(32'hFC000000, cyc, pulses, regWes, trace, s2, sl);
    checkOutput("nop_trace", trace, 32'h1C);
    checkOutput("nop_pc_we", {31'h0, sl.pcWe}, 32'd1);
    checkOutput("nop_nPC_sel", {30'h0, sl.nPc}, 32'd0);
    checkOutput("trap_state", {28'h0, stO[H]}, 32'd13);
    checkOutput("trap_illegal", {31'h0, illO[H]}, 32'd1);
    hPulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      hPulses += int'(pcWeO[H]);
    end
    checkOutput("trap_no_pc_we", hPulses, 32'd0);
    checkOutput("trap_cnt_frozen", {28'h0, cntO[H]}, 32'd6);
    checkOutput("trap_sticky", {31'h0, illO[H]}, 32'd1);

    // Reset in the middle of a load's write-back cycle.
    doReset();
    applyStimulus(32'h00221821, cyc, pulses, regWes, trace, s2, sl);
    instruction = 32'h8C220004;
    for (int i = 0; i < 10 && stO[N] != 4'd8; i++) @(negedge clk);
    checkOutput("midrst_reached_wb_mem", {28'h0, stO[N]}, 32'd8);
    #1 rst = 1'b1;
    #1;
    checkOutput("midrst_state", {28'h0, stO[N]}, 32'd0);
    checkOutput("midrst_ir", irO[N], 32'd0);
    checkOutput("midrst_pc_we", {31'h0, pcWeO[N]}, 32'd0);
    checkOutput("midrst_reg_we", {31'h0, regWeO[N]}, 32'd0);
    checkOutput("midrst_cnt", {28'h0, cntO[N]}, 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;

    // Counter wrap: 15 retirements reach all-ones, the 16th wraps to zero.
    for (int i = 0; i < 15; i++) begin
      applyStimulus(randInstr($urandom_range(0, 9)), cyc, pulses, regWes, trace, s2, sl);
    end
    checkOutput("wrap_allones", {28'h0, cntO[N]}, 32'd15);
    applyStimulus(randInstr($urandom_range(0, 9)), cyc, pulses, regWes, trace, s2, sl);
    checkOutput("wrap_zero_nop", {28'h0, cntO[N]}, 32'd0);
    checkOutput("wrap_zero_halt", {28'h0, cntO[H]}, 32'd0);

    // Random mix including illegal words; reset after each trap.
    for (int i = 0; i < 300; i++) begin
      k = $urandom_range(0, 11);
      if (k > K_BAD) k = K_BAD;
      applyStimulus(randInstr(k), cyc, pulses, regWes, trace, s2, sl);
      if (k == K_BAD) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        doReset();
      end
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
